// File: rtl/puf_uart_pkg.sv
// Shared constants and state encoding for the PUF/UART sequencer.
package puf_uart_pkg;

  localparam logic [7:0] HDR_CMD  = 8'hA5;
  localparam logic [7:0] HDR_RESP = 8'h5A;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    RX_CHAL,
    FIRE,
    WAIT_PUF,
    TX_HDR,
    TX_RESP,
    TX_ERR
  } state_e;

endpackage

// File: rtl/puf_uart_timer.sv
// Clearable up-counter with an equality compare against a runtime limit.
// One instance is shared between the RX inter-byte timeout and the PUF timeout.
module puf_uart_timer #(
  parameter int W = 20
) (
  input  logic         clk_100mhz,
  input  logic         resetn,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  // Count every cycle unless cleared; the owner clears on state entry and on activity.
  always_ff @(posedge clk_100mhz or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/puf_uart_sequencer.sv
// Frames challenges from the UART byte stream, fires the PUF core and
// returns either a framed response or an error byte to the transmitter.
module puf_uart_sequencer
  import puf_uart_pkg::*;
#(
  parameter int CHAL_BYTES  = 8,
  parameter int RESP_BYTES  = 4,
  parameter int PUF_TIMEOUT = 1000000,
  parameter int RX_TIMEOUT  = 100000
) (
  input  logic                    clk_100mhz,
  input  logic                    resetn,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic [8*CHAL_BYTES-1:0] puf_challenge,
  output logic                    puf_start,
  input  logic                    puf_done,
  input  logic [8*RESP_BYTES-1:0] puf_response,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int CW     = 8 * CHAL_BYTES;
  localparam int RW     = 8 * RESP_BYTES;
  localparam int MAX_TO = (PUF_TIMEOUT > RX_TIMEOUT) ? PUF_TIMEOUT : RX_TIMEOUT;
  localparam int TW     = $clog2(MAX_TO);

  localparam logic [TW-1:0] RX_LIM   = TW'(RX_TIMEOUT - 1);
  localparam logic [TW-1:0] PUF_LIM  = TW'(PUF_TIMEOUT - 1);
  localparam logic [4:0]    CHAL_END = 5'(CHAL_BYTES - 1);
  localparam logic [4:0]    RESP_END = 5'(RESP_BYTES - 1);

  state_e         state, next_state;
  logic [CW-1:0]  chal_q;
  logic [RW-1:0]  resp_q;
  logic [4:0]     byte_cnt;

  logic           timer_clear;
  logic [TW-1:0]  timer_limit;
  logic           timer_expired;
  logic           chal_shift;
  logic           resp_load;
  logic           resp_shift;
  logic           cnt_clear;
  logic           cnt_inc;
  logic           err_set;

  puf_uart_timer #(
    .W(TW)
  ) u_timer (
    .clk_100mhz(clk_100mhz),
    .resetn    (resetn),
    .clear     (timer_clear),
    .limit     (timer_limit),
    .expired   (timer_expired)
  );

  // State register.
  always_ff @(posedge clk_100mhz or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the per-state datapath strobes and tx offer.
  always_comb begin
    next_state  = state;
    timer_clear = 1'b0;
    timer_limit = RX_LIM;
    chal_shift  = 1'b0;
    resp_load   = 1'b0;
    resp_shift  = 1'b0;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    err_set     = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    puf_start   = 1'b0;

    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        cnt_clear   = 1'b1;
        if (rx_valid && (rx_data == HDR_CMD)) begin
          next_state = RX_CHAL;
        end
      end

      RX_CHAL: begin
        if (rx_valid) begin
          chal_shift  = 1'b1;
          cnt_inc     = 1'b1;
          timer_clear = 1'b1;
          if (byte_cnt == CHAL_END) begin
            next_state = FIRE;
          end
        end else if (timer_expired) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end
      end

      FIRE: begin
        puf_start   = 1'b1;
        timer_clear = 1'b1;
        next_state  = WAIT_PUF;
      end

      WAIT_PUF: begin
        timer_limit = PUF_LIM;
        if (puf_done) begin
          resp_load  = 1'b1;
          next_state = TX_HDR;
        end else if (timer_expired) begin
          err_set    = 1'b1;
          next_state = TX_ERR;
        end
      end

      TX_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_RESP;
        if (tx_ready) begin
          cnt_clear  = 1'b1;
          next_state = TX_RESP;
        end
      end

      TX_RESP: begin
        tx_valid = 1'b1;
        tx_data  = resp_q[RW-1 -: 8];
        if (tx_ready) begin
          resp_shift = 1'b1;
          cnt_inc    = 1'b1;
          if (byte_cnt == RESP_END) begin
            next_state = IDLE;
          end
        end
      end

      TX_ERR: begin
        tx_valid = 1'b1;
        tx_data  = ERR_BYTE;
        if (tx_ready) begin
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Challenge/response shift registers, byte counter and the timeout pulse.
  always_ff @(posedge clk_100mhz or negedge resetn) begin
    if (!resetn) begin
      chal_q      <= '0;
      resp_q      <= '0;
      byte_cnt    <= 5'd0;
      err_timeout <= 1'b0;
    end else begin
      if (chal_shift) begin
        chal_q <= (chal_q << 8) | CW'(rx_data);
      end
      if (resp_load) begin
        resp_q <= puf_response;
      end else if (resp_shift) begin
        resp_q <= resp_q << 8;
      end
      if (cnt_clear) begin
        byte_cnt <= 5'd0;
      end else if (cnt_inc) begin
        byte_cnt <= byte_cnt + 5'd1;
      end
      err_timeout <= err_set;
    end
  end

  assign puf_challenge = chal_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_puf_uart_sequencer.sv
// Directed self-checking bench for puf_uart_sequencer with small timeouts.
module tb_puf_uart_sequencer;

  localparam int CB = 8;
  localparam int RB = 4;
  localparam int PT = 50;
  localparam int RT = 40;

  logic            clk;
  logic            resetn;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic [8*CB-1:0] puf_challenge;
  logic            puf_start;
  logic            puf_done;
  logic [8*RB-1:0] puf_response;
  logic            busy;
  logic            err_timeout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Monitor-owned statistics
  logic [7:0] tx_q[$];
  int start_cnt = 0, start_cyc = 0, err_cnt = 0, err_cyc = 0;
  int first_tx_cyc = 0, stall_bad = 0;
  logic prev_tx_valid = 1'b0;
  logic stall_pending = 1'b0;
  logic [7:0] stall_data = 8'h00;

  // PUF model state
  int puf_answer = 1;
  logic [31:0] resp_val = 32'hDEADBEEF;
  int countdown = 0, done_cyc = 0, strobe_req = 0, strobe_seen = 0;

  // Ready driver state
  int rand_mode = 0;
  int last_rx_cyc = 0;

  puf_uart_sequencer #(
    .CHAL_BYTES (CB),
    .RESP_BYTES (RB),
    .PUF_TIMEOUT(PT),
    .RX_TIMEOUT (RT)
  ) dut (
    .clk_100mhz   (clk),
    .resetn       (resetn),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .puf_challenge(puf_challenge),
    .puf_start    (puf_start),
    .puf_done     (puf_done),
    .puf_response (puf_response),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Transmitter ready: always high unless the random-stall mode is on
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = (rand_mode != 0) ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // PUF core model: answers 10 cycles after start, or strobes done on request
  initial begin
    puf_done     = 1'b0;
    puf_response = '0;
    forever begin
      @(posedge clk);
      #1;
      puf_done = 1'b0;
      if (countdown > 0) begin
        countdown = countdown - 1;
        if (countdown == 0) begin
          puf_done     = 1'b1;
          puf_response = resp_val;
          done_cyc     = cyc;
        end
      end else if (puf_start && (puf_answer != 0)) begin
        countdown = 10;
      end else if (strobe_req != strobe_seen) begin
        strobe_seen  = strobe_req;
        puf_done     = 1'b1;
        puf_response = 32'hCAFEF00D;
      end
    end
  end

  // Output monitor sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (stall_pending && tx_valid && (tx_data != stall_data)) stall_bad = stall_bad + 1;
      stall_pending = tx_valid && !tx_ready;
      stall_data    = tx_data;
      if (tx_valid && !prev_tx_valid) first_tx_cyc = cyc;
      prev_tx_valid = tx_valid;
      if (puf_start) begin
        start_cnt = start_cnt + 1;
        start_cyc = cyc;
      end
      if (err_timeout) begin
        err_cnt = err_cnt + 1;
        err_cyc = cyc;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid    = 1'b1;
    rx_data     = b;
    last_rx_cyc = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendChallenge(input logic [7:0] base);
    for (int i = 1; i <= CB; i++) applyStimulus(base + 8'(i));
  endtask

  task automatic waitIdle(input string tag, input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && (n < max_cycles));
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic checkTx(input string tag, input int base, input int n, input logic [39:0] exp);
    checkOutput({tag, "_len"}, 64'(tx_q.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < tx_q.size())
        checkOutput($sformatf("%s_byte%0d", tag, i), 64'(tx_q[base + i]), 64'(exp[8*(n-1-i) +: 8]));
    end
  endtask

  initial begin
    int q0, s0, e0, last_chal, n;

    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_valid", 64'(tx_valid), 64'd0);
    checkOutput("rst_tx_data", 64'(tx_data), 64'd0);
    checkOutput("rst_puf_start", 64'(puf_start), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err", 64'(err_timeout), 64'd0);
    checkOutput("rst_chal", 64'(puf_challenge), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Noise before a header and a stray done in IDLE
    q0 = tx_q.size();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h5A);
    @(negedge clk);
    checkOutput("noise_busy", 64'(busy), 64'd0);
    strobe_req = strobe_req + 1;
    repeat (6) @(negedge clk);
    checkOutput("idle_done_busy", 64'(busy), 64'd0);
    checkOutput("idle_done_notx", 64'(tx_q.size()), 64'(q0));
    checkOutput("noise_chal", 64'(puf_challenge), 64'd0);

    // Frame 1: normal response, stray bytes during WAIT_PUF
    q0 = tx_q.size(); s0 = start_cnt; e0 = err_cnt;
    resp_val = 32'hDEADBEEF;
    applyStimulus(8'hA5);
    sendChallenge(8'h00);
    last_chal = last_rx_cyc;
    applyStimulus(8'hA5);
    applyStimulus(8'h77);
    n = 0;
    while ((tx_q.size() < q0 + 1) && (n < 100)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("f1_tx_started", 64'(tx_q.size() >= q0 + 1), 64'd1);
    puf_answer = 0;
    n = 0;
    while ((cyc != first_tx_cyc + 4) && (n < 20)) begin
      @(posedge clk);
      #1;
      n++;
    end
    // Back-to-back header in the first IDLE cycle
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(negedge clk);
    checkOutput("f1_busy_low", 64'(busy), 64'd0);
    checkOutput("f1_tx_valid_off", 64'(tx_valid), 64'd0);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_accepted", 64'(busy), 64'd1);
    checkOutput("f1_chal", 64'(puf_challenge), 64'h0102030405060708);
    checkOutput("f1_starts", 64'(start_cnt - s0), 64'd1);
    checkOutput("f1_start_lat", 64'(start_cyc - last_chal), 64'd1);
    checkOutput("f1_done_to_tx", 64'(first_tx_cyc - done_cyc), 64'd1);
    checkOutput("f1_no_err", 64'(err_cnt - e0), 64'd0);
    checkTx("f1_tx", q0, 5, 40'h5ADEADBEEF);

    // Frame 2: PUF never answers
    q0 = tx_q.size(); e0 = err_cnt;
    sendChallenge(8'h00);
    waitIdle("f2", PT + 60);
    checkOutput("f2_err_count", 64'(err_cnt - e0), 64'd1);
    checkOutput("f2_err_time", 64'(err_cyc - start_cyc), 64'(PT + 1));
    checkTx("f2_tx", q0, 1, 40'h00000000EE);

    // RX timeout after a partial challenge
    q0 = tx_q.size(); s0 = start_cnt; e0 = err_cnt;
    puf_answer = 1;
    applyStimulus(8'hA5);
    applyStimulus(8'h21);
    applyStimulus(8'h22);
    applyStimulus(8'h23);
    waitIdle("rxto", RT + 20);
    checkOutput("rxto_err_count", 64'(err_cnt - e0), 64'd1);
    checkOutput("rxto_err_time", 64'(err_cyc - last_rx_cyc), 64'(RT + 1));
    checkOutput("rxto_no_tx", 64'(tx_q.size()), 64'(q0));
    checkOutput("rxto_no_start", 64'(start_cnt - s0), 64'd0);

    // Frame 3: recovers normally with a new challenge and response
    q0 = tx_q.size();
    resp_val = 32'h01234567;
    applyStimulus(8'hA5);
    sendChallenge(8'h10);
    waitIdle("f3", 100);
    checkOutput("f3_chal", 64'(puf_challenge), 64'h1112131415161718);
    checkTx("f3_tx", q0, 5, 40'h5A01234567);

    // Frame 4: random back-pressure on the transmitter
    q0 = tx_q.size();
    resp_val  = 32'hDEADBEEF;
    rand_mode = 1;
    applyStimulus(8'hA5);
    sendChallenge(8'h00);
    waitIdle("f4", 400);
    rand_mode = 0;
    checkOutput("f4_stall_stable", 64'(stall_bad), 64'd0);
    checkTx("f4_tx", q0, 5, 40'h5ADEADBEEF);

    // Frame 5: reset while two response bytes have gone out
    repeat (2) @(negedge clk);
    q0 = tx_q.size();
    applyStimulus(8'hA5);
    sendChallenge(8'h00);
    n = 0;
    while ((tx_q.size() < q0 + 3) && (n < 100)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("f5_reached_resp", 64'(tx_q.size() - q0), 64'd3);
    #2 resetn = 1'b0;
    #1;
    checkOutput("f5_rst_tx_valid", 64'(tx_valid), 64'd0);
    checkOutput("f5_rst_tx_data", 64'(tx_data), 64'd0);
    checkOutput("f5_rst_busy", 64'(busy), 64'd0);
    checkOutput("f5_rst_chal", 64'(puf_challenge), 64'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("f5_no_more_tx", 64'(tx_q.size() - q0), 64'd3);
    checkOutput("f5_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
